// File: rtl/fft_spi_cmd_ctrl_pkg.sv
// Shared opcodes, FSM state type and status-byte layout for fft_spi_cmd_ctrl.
package fft_ctrl_pkg;

  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_START  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    LD_HI,
    LD_LO,
    RD_ADDR,
    RD_HI,
    RD_WAIT,
    RD_LO,
    DISCARD
  } state_t;

  localparam int unsigned STS_BUSY_BIT = 0;
  localparam int unsigned STS_DONE_BIT = 1;
  localparam int unsigned STS_ERR_BIT  = 2;

  function automatic logic [7:0] status_byte(input logic err, input logic done,
                                             input logic busy);
    logic [7:0] s;
    s               = '0;
    s[STS_ERR_BIT]  = err;
    s[STS_DONE_BIT] = done;
    s[STS_BUSY_BIT] = busy;
    return s;
  endfunction

endpackage

// File: rtl/fft_spi_cmd_ctrl.sv
// SPI command sequencer: LOAD/START/READ/STATUS between the SPI byte slave and the FFT core.
// Optional FFTCTRL_IRQ_EN: registered irq = done_sticky | err; tied 0 otherwise.
module fft_spi_cmd_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                slave_sel,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic [7:0]          tx_data,
  output logic                tx_load,
  input  logic                tx_done,
  output logic                buf_we,
  output logic [ADDR_W-1:0]   buf_addr,
  output logic [SAMPLE_W-1:0] buf_wdata,
  input  logic [SAMPLE_W-1:0] buf_rdata,
  output logic                fft_start,
  input  logic                fft_busy,
  input  logic                fft_done,
  output logic                irq
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi_q;
  logic [7:0]        lo_q;
  logic              err;
  logic              done_sticky;

  logic cmd_valid;
  logic err_set;
  logic sts_rd;
  logic start_ok;
  logic err_n;
  logic done_n;

  // Flag updates are decoded here so the optional irq register sees the same next values.
  always_comb begin
    cmd_valid = (state == IDLE) && rx_valid && !slave_sel;
    err_set   = 1'b0;
    sts_rd    = 1'b0;
    start_ok  = 1'b0;
    if (cmd_valid) begin
      case (rx_data)
        CMD_LOAD, CMD_READ: err_set = fft_busy;
        CMD_START: begin
          err_set  = fft_busy;
          start_ok = !fft_busy;
        end
        CMD_STATUS: sts_rd = 1'b1;
        default:    err_set = 1'b1;
      endcase
    end
    err_n  = err_set ? 1'b1 : (sts_rd ? 1'b0 : err);
    done_n = fft_done ? 1'b1 : ((sts_rd || start_ok) ? 1'b0 : done_sticky);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      err         <= 1'b0;
      done_sticky <= 1'b0;
      tx_data     <= '0;
      tx_load     <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      fft_start   <= 1'b0;
    end else begin
      err         <= err_n;
      done_sticky <= done_n;
      tx_load     <= 1'b0;
      buf_we      <= 1'b0;
      fft_start   <= 1'b0;
      if (slave_sel) begin
        state <= IDLE;
        addr  <= '0;
        hi_q  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid) begin
              case (rx_data)
                CMD_LOAD: begin
                  addr  <= '0;
                  state <= fft_busy ? DISCARD : LD_HI;
                end
                CMD_START: fft_start <= start_ok;
                CMD_READ: begin
                  addr     <= '0;
                  buf_addr <= '0;
                  state    <= fft_busy ? DISCARD : RD_ADDR;
                end
                CMD_STATUS: begin
                  tx_data <= status_byte(err, done_sticky, fft_busy);
                  tx_load <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          LD_HI: begin
            if (rx_valid) begin
              hi_q  <= rx_data;
              state <= LD_LO;
            end
          end
          LD_LO: begin
            if (rx_valid) begin
              buf_we    <= 1'b1;
              buf_wdata <= {hi_q, rx_data};
              buf_addr  <= addr;
              addr      <= addr + ADDR_W'(1);
              state     <= (addr == '1) ? IDLE : LD_HI;
            end
          end
          RD_ADDR: state <= RD_HI;
          RD_HI: begin
            // Both bytes are captured now; the RAM may be rewritten before the low byte goes out.
            tx_data <= buf_rdata[15:8];
            lo_q    <= buf_rdata[7:0];
            tx_load <= 1'b1;
            state   <= RD_WAIT;
          end
          RD_WAIT: begin
            if (tx_done) begin
              tx_data <= lo_q;
              tx_load <= 1'b1;
              state   <= RD_LO;
            end
          end
          RD_LO: begin
            if (tx_done) begin
              if (addr == '1) begin
                addr  <= '0;
                state <= IDLE;
              end else begin
                addr     <= addr + ADDR_W'(1);
                buf_addr <= addr + ADDR_W'(1);
                state    <= RD_ADDR;
              end
            end
          end
          DISCARD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FFTCTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= done_n | err_n;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fft_spi_cmd_ctrl.sv
// Self-checking bench for fft_spi_cmd_ctrl (ADDR_W=2): directed sequences, an opcode table,
// and random command streams against a transaction-level reference model.
module tb_fft_spi_cmd_ctrl;

  localparam int ADDR_W = 2;
  localparam int N      = 4;
  localparam int GAP    = 6;
  localparam int M_IDLE = 0, M_LOAD = 1, M_READ = 2, M_DISC = 3;

  logic              clk = 1'b0;
  logic              reset, slave_sel, rx_valid, tx_done, fft_busy, fft_done;
  logic [7:0]        rx_data, tx_data;
  logic              tx_load, buf_we, fft_start, irq;
  logic [ADDR_W-1:0] buf_addr;
  logic [15:0]       buf_wdata, buf_rdata;

  always #5 clk = ~clk;

  fft_spi_cmd_ctrl #(.ADDR_W(ADDR_W), .SAMPLE_W(16)) dut (
    .clk(clk), .reset(reset), .slave_sel(slave_sel), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load), .tx_done(tx_done),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .fft_start(fft_start), .fft_busy(fft_busy), .fft_done(fft_done), .irq(irq)
  );

  // Synchronous sample buffer: read data one cycle after the address.
  logic [15:0] mem [N];
  always @(posedge clk) buf_rdata <= mem[buf_addr];

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic irq_exp(input logic v);
`ifdef FFTCTRL_IRQ_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Observed traffic
  logic [7:0]  obs_tx[$];
  int          obs_wr_addr[$];
  logic [15:0] obs_wr_data[$];
  int          obs_start, tx_viol, tx_cnt, fft_cnt;
  bit          tx_out, auto_fft, use_model;

  // Reference model
  logic [7:0]  exp_tx[$];
  int          exp_wr_addr[$];
  logic [15:0] exp_wr_data[$];
  logic [15:0] m_mem [N];
  int          exp_start, mode, m_idx;
  logic [7:0]  m_hi;
  bit          m_hiphase, m_err, m_done, p_dset, p_dclr, p_eset, p_eclr;

  task automatic tick();
    @(posedge clk); #1;
    if (p_dset) m_done = 1'b1; else if (p_dclr) m_done = 1'b0;
    if (p_eset) m_err = 1'b1;  else if (p_eclr) m_err = 1'b0;
    {p_dset, p_dclr, p_eset, p_eclr} = '0;
    if (buf_we) begin
      mem[buf_addr] = buf_wdata;
      obs_wr_addr.push_back(int'(buf_addr));
      obs_wr_data.push_back(buf_wdata);
    end
    if (fft_start) obs_start++;
    tx_done = 1'b0;
    if (slave_sel) tx_out = 1'b0;
    if (tx_load) begin
      if (tx_out) tx_viol++;
      obs_tx.push_back(tx_data);
      tx_out = 1'b1;
      tx_cnt = int'($urandom_range(3, 0));
    end else if (tx_out) begin
      if (tx_cnt == 0) begin tx_done = 1'b1; tx_out = 1'b0; end
      else tx_cnt--;
    end
    if (auto_fft) begin
      fft_done = 1'b0;
      if (fft_busy) begin
        if (fft_cnt == 0) begin fft_busy = 1'b0; fft_done = 1'b1; end
        else fft_cnt--;
      end else if (fft_start) begin
        fft_busy = 1'b1;
        fft_cnt  = int'($urandom_range(40, 5));
      end
    end
    p_dset = fft_done;
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (mode)
      M_IDLE: begin
        case (b)
          8'h01: if (fft_busy) begin p_eset = 1; mode = M_DISC; end
                 else begin mode = M_LOAD; m_idx = 0; m_hiphase = 1; end
          8'h02: if (fft_busy) p_eset = 1; else begin exp_start++; p_dclr = 1; end
          8'h03: if (fft_busy) begin p_eset = 1; mode = M_DISC; end
                 else begin
                   mode = M_READ;
                   for (int i = 0; i < N; i++) begin
                     exp_tx.push_back(m_mem[i][15:8]);
                     exp_tx.push_back(m_mem[i][7:0]);
                   end
                 end
          8'h04: begin
            exp_tx.push_back({5'b0, m_err, m_done, fft_busy});
            p_eclr = 1; p_dclr = 1;
          end
          default: p_eset = 1;
        endcase
      end
      M_LOAD: begin
        if (m_hiphase) begin m_hi = b; m_hiphase = 0; end
        else begin
          m_mem[m_idx] = {m_hi, b};
          exp_wr_addr.push_back(m_idx);
          exp_wr_data.push_back({m_hi, b});
          m_idx++;
          m_hiphase = 1;
          if (m_idx == N) mode = M_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    if (use_model) model_byte(b);
    tick();
    rx_valid = 1'b0;
    repeat (GAP) tick();
  endtask

  task automatic abort_txn();
    slave_sel = 1'b1;
    mode      = M_IDLE;
    tick();
    slave_sel = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_tx(input int n);
    int guard = 0;
    while (obs_tx.size() < n && guard < 400) begin tick(); guard++; end
  endtask

  task automatic cmp_tx(input string tag);
    check($sformatf("%s tx count", tag), obs_tx.size(), exp_tx.size());
    for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
      check($sformatf("%s tx[%0d]", tag, i), obs_tx[i], exp_tx[i]);
    obs_tx.delete(); exp_tx.delete();
  endtask

  task automatic cmp_wr(input string tag);
    check($sformatf("%s write count", tag), obs_wr_addr.size(), exp_wr_addr.size());
    for (int i = 0; i < obs_wr_addr.size() && i < exp_wr_addr.size(); i++) begin
      check($sformatf("%s wr[%0d] addr", tag, i), obs_wr_addr[i], exp_wr_addr[i]);
      check($sformatf("%s wr[%0d] data", tag, i), obs_wr_data[i], exp_wr_data[i]);
    end
    obs_wr_addr.delete(); obs_wr_data.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; slave_sel = 1'b1;
    repeat (3) tick();
    reset = 1'b0; slave_sel = 1'b0;
    tick();
    {m_err, m_done, p_dset, p_dclr, p_eset, p_eclr, tx_out} = '0;
    mode = M_IDLE; obs_start = 0; exp_start = 0; tx_viol = 0;
    obs_tx.delete(); exp_tx.delete();
    obs_wr_addr.delete(); obs_wr_data.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
  endtask

  typedef struct {
    logic [7:0] op;
    logic       busy;
    int         starts;
    logic [7:0] sts;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ld_a[8];
    logic [7:0] ld_b[8];
    for (int i = 0; i < N; i++) begin mem[i] = '0; m_mem[i] = '0; end
    {reset, slave_sel, rx_valid, tx_done, fft_busy, fft_done} = '0;
    rx_data = '0; auto_fft = 0; use_model = 0;
    do_reset();
    check("reset tx_load", tx_load, 0);
    check("reset tx_data", tx_data, 0);
    check("reset buf_we", buf_we, 0);
    check("reset buf_addr", buf_addr, 0);
    check("reset buf_wdata", buf_wdata, 0);
    check("reset fft_start", fft_start, 0);
    check("reset irq", irq, 0);

    // Full LOAD of four words
    ld_a = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    send_byte(8'h01);
    foreach (ld_a[i]) send_byte(ld_a[i]);
    exp_wr_addr = '{0, 1, 2, 3};
    exp_wr_data = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    cmp_wr("load4");
    send_byte(8'h04);
    exp_tx = '{8'h00};
    cmp_tx("load4 idle status");

    // START, completion, STATUS reporting and clearing
    obs_start = 0;
    send_byte(8'h02);
    check("start pulse count", obs_start, 1);
    fft_busy = 1'b1; repeat (5) tick();
    fft_busy = 1'b0; fft_done = 1'b1; tick(); fft_done = 1'b0; repeat (2) tick();
    check("irq after done", irq, irq_exp(1'b1));
    send_byte(8'h04);
    check("irq after status", irq, 0);
    send_byte(8'h04);
    exp_tx = '{8'h02, 8'h00};
    cmp_tx("done status");

    // READ back a preloaded frame
    ld_b = '{8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_byte(8'h01);
    foreach (ld_b[i]) send_byte(ld_b[i]);
    obs_wr_addr.delete(); obs_wr_data.delete();
    tx_viol = 0;
    send_byte(8'h03);
    wait_tx(2 * N);
    repeat (8) tick();
    exp_tx = '{8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cmp_tx("read frame");
    check("read tx overlap", tx_viol, 0);
    send_byte(8'h04);
    exp_tx = '{8'h00};
    cmp_tx("read idle status");

    // LOAD while busy: discard until deselect
    fft_busy = 1'b1;
    send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    cmp_wr("busy load");
    check("busy load irq", irq, irq_exp(1'b1));
    abort_txn();
    send_byte(8'h04);
    fft_busy = 1'b0;
    send_byte(8'h04);
    exp_tx = '{8'h05, 8'h00};
    cmp_tx("busy load status");

    // LOAD aborted mid-word, then restart at addr 0
    send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    abort_txn();
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    abort_txn();
    exp_wr_addr = '{0, 0};
    exp_wr_data = '{16'hAABB, 16'h1234};
    cmp_wr("abort load");

    // Byte arriving with deselect is dropped
    send_byte(8'h01); send_byte(8'h56);
    rx_valid = 1'b1; rx_data = 8'h78; slave_sel = 1'b1;
    tick();
    rx_valid = 1'b0; slave_sel = 1'b0;
    repeat (GAP) tick();
    send_byte(8'h04);
    cmp_wr("deselect drop");
    exp_tx = '{8'h00};
    cmp_tx("deselect status");

    // Bad opcode, then fft_done colliding with the STATUS clear
    send_byte(8'h7F);
    rx_valid = 1'b1; rx_data = 8'h04; fft_done = 1'b1;
    tick();
    rx_valid = 1'b0; fft_done = 1'b0;
    repeat (GAP) tick();
    check("collide irq", irq, irq_exp(1'b1));
    send_byte(8'h04);
    send_byte(8'h04);
    exp_tx = '{8'h04, 8'h02, 8'h00};
    cmp_tx("collide status");

    // Opcode table: op under a given busy level, deselect, then STATUS
    vecs = '{
      '{8'h02, 1'b0, 1, 8'h00}, '{8'h02, 1'b1, 0, 8'h05}, '{8'h01, 1'b1, 0, 8'h05},
      '{8'h03, 1'b1, 0, 8'h05}, '{8'h7F, 1'b0, 0, 8'h04}, '{8'h00, 1'b1, 0, 8'h05},
      '{8'hFF, 1'b0, 0, 8'h04}, '{8'h05, 1'b0, 0, 8'h04}, '{8'h04, 1'b1, 0, 8'h01},
      '{8'h01, 1'b0, 0, 8'h00}, '{8'h03, 1'b0, 0, 8'h00}
    };
    for (int v = 0; v < 11; v++) begin
      fft_busy  = vecs[v].busy;
      obs_start = 0;
      send_byte(vecs[v].op);
      abort_txn();
      obs_tx.delete();
      send_byte(8'h04);
      check($sformatf("vec%0d starts", v), obs_start, vecs[v].starts);
      exp_tx = '{vecs[v].sts};
      cmp_tx($sformatf("vec%0d", v));
      fft_busy = 1'b0;
      send_byte(8'h04);
      obs_tx.delete();
    end

    // Random command streams against the reference model
    do_reset();
    auto_fft = 1; use_model = 1;
    for (int t = 0; t < 30; t++) begin
      int k;
      k = (t == 0) ? 0 : int'($urandom_range(5, 0));
      case (k)
        0: begin
          send_byte(8'h01);
          if (mode == M_DISC) abort_txn();
          else for (int i = 0; i < 2 * N; i++) send_byte(8'($urandom));
        end
        1: begin
          int nb;
          nb = int'($urandom_range(2 * N - 1, 1));
          send_byte(8'h01);
          for (int i = 0; i < nb; i++) send_byte(8'($urandom));
          abort_txn();
        end
        2: send_byte(8'h02);
        3: begin
          send_byte(8'h03);
          if (mode == M_DISC) abort_txn();
          else begin
            wait_tx(exp_tx.size());
            repeat (8) tick();
            mode = M_IDLE;
          end
        end
        4: send_byte(8'h04);
        default: send_byte(8'($urandom_range(255, 5)));
      endcase
      repeat (4) tick();
      cmp_tx($sformatf("rnd%0d", t));
      cmp_wr($sformatf("rnd%0d", t));
      check($sformatf("rnd%0d starts", t), obs_start, exp_start);
      check($sformatf("rnd%0d irq", t), irq, irq_exp(m_err | m_done));
    end
    check("rnd tx overlap", tx_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
